// File: rtl/lsh_seq.sv
// Multi-cycle logical left shifter (SLL/SLLV) with valid/ready handshakes.
// Shifts the captured operand by up to STEP bits per clock, zero-filling from the LSB.
//
// state | meaning
// IDLE  | waiting for an operand; in_ready high
// SHIFT | applying up to STEP bits of shift per cycle
// DONE  | result held on res until out_ready
module lsh_seq #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP_W = 5'(STEP);

  state_t      state;
  logic [31:0] acc;
  logic [4:0]  rem;
  logic        unused_shamt;

  assign unused_shamt = ^shamt[31:5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
    end else if (flush) begin
      // abort keeps acc so res does not glitch; only the control path is cleared
      state <= IDLE;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= a;
            rem   <= shamt[4:0];
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (rem > STEP_W) begin
            acc <= acc << STEP;
            rem <= rem - STEP_W;
          end else begin
            acc   <= acc << rem;
            rem   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n & (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign res       = acc;

endmodule

// File: tb/tb_lsh_seq.sv
// Directed + randomized bench for lsh_seq (STEP=4) with a result/latency scoreboard.
module tb_lsh_seq;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  lsh_seq #(.STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // edges from the accepting edge (counted as 1) until out_valid is seen
  function automatic int exp_lat(input logic [4:0] s);
    int n;
    n = (s == 0) ? 1 : (int'(s) + STEP - 1) / STEP;
    return n + 1;
  endfunction

  task automatic start_op(input logic [31:0] av, input logic [31:0] sv);
    int   budget;
    exp_t e;
    @(negedge clk);
    a = av; shamt = sv; in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    e.res = av << sv[4:0];
    e.lat = exp_lat(sv[4:0]);
    sb.push_back(e);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic collect(input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("out_valid", 32'(out_valid), 32'd1);
    check("latency", 32'(lat), 32'(e.lat));
    check("res", res, e.res);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("idle_after_xfer", {30'd0, busy, in_ready}, 32'b01);
  endtask

  task automatic run_op(input logic [31:0] av, input logic [31:0] sv);
    int lat;
    start_op(av, sv);
    wait_out(lat);
    collect(lat);
    release_out();
  endtask

  initial begin
    int          lat;
    logic [31:0] held;
    logic        seen;

    // reset state
    #12;
    check("rst_res", res, 32'd0);
    check("rst_flags", {29'd0, out_valid, busy, in_ready}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("post_rst_ready", 32'(in_ready), 32'd1);

    // full range, upper shamt bits ignored, zero shift
    run_op(32'h0000_0001, 32'd31);
    run_op(32'hFFFF_FFFF, 32'h0000_0025);
    run_op(32'h1234_5678, 32'd0);
    run_op(32'hDEAD_BEEF, 32'hFFFF_FFE4);

    // back-pressure for 10 cycles, then a back-to-back offer
    start_op(32'h0000_00F3, 32'd7);
    wait_out(lat);
    collect(lat);
    held = res;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_res", res, held);
      check("bp_flags", {30'd0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'h8000_0003; shamt = 32'd2;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("bp_release", {30'd0, busy, in_ready}, 32'b01);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_next_accept", 32'(busy), 32'd1);
    begin
      exp_t e;
      e.res = 32'h0000_000C;
      e.lat = 2;
      sb.push_back(e);
    end
    wait_out(lat);
    collect(lat);
    release_out();

    // flush during the 3rd SHIFT cycle of s=31
    start_op(32'h0000_0001, 32'd31);
    void'(sb.pop_back());
    @(posedge clk);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_shift_idle", {30'd0, busy, in_ready}, 32'b01);
    check("flush_keeps_acc", res, 32'h0000_0100);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 seen = seen | out_valid;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // flush in DONE with out_ready high drops the result
    start_op(32'h0000_0011, 32'd4);
    void'(sb.pop_back());
    wait_out(lat);
    check("flush_done_reached", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; out_ready = 1'b0;
    check("flush_done_drop", {30'd0, out_valid, busy}, 32'd0);
    check("flush_done_res", res, 32'h0000_0110);

    // asynchronous reset mid-SHIFT
    start_op(32'hABCD_0001, 32'd31);
    void'(sb.pop_back());
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_res", res, 32'd0);
    check("arst_flags", {29'd0, out_valid, busy, in_ready}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("arst_ready", 32'(in_ready), 32'd1);

    // every shift amount with random operands and random ignored upper bits
    for (int s = 0; s < 32; s++) begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] sv;
        sv = {$urandom_range(0, 32'h07FF_FFFF), 5'(s)};
        sv[31:5] = 27'($urandom);
        run_op($urandom, sv);
      end
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
